dbg_icb_arb: RTL and testbench

DBG_ICB_ARB -- requirements
Module: dbg_icb_arb

---
 rtl/dbg_icb_arb.sv | 233 +++++++++++++++++++++++
 tb/tb_dbg_icb_arb.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_icb_arb.sv
// ---------------------------------------------------------------------------
// dbg_icb_arb
//
// Two-master to one-slave ICB arbiter. Master 0 is the JTAG debug port,
// master 1 is the core LSU. One transaction is in flight at a time. A slave
// that stops responding is cut off by a timeout: the master receives an error
// response, and the late slave response is drained and dropped.
//
// Ports
//   clk, rst           single clock, asynchronous active-high reset
//   m0_cmd_* / m0_rsp_*  master 0 command and response channels
//   m1_cmd_* / m1_rsp_*  master 1 command and response channels
//   s_cmd_*  / s_rsp_*   slave command and response channels
//   busy               transaction in flight or late response pending
//   tmo_pulse          one-cycle pulse in the cycle the timeout fires
//
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where valid and ready are both high. The sender holds valid and payload
// stable until that edge. ready may depend combinationally on valid.
// ---------------------------------------------------------------------------
module dbg_icb_arb #(
    parameter int TMO_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cmd_valid,
    output logic        m0_cmd_ready,
    input  logic [31:0] m0_cmd_addr,
    input  logic [31:0] m0_cmd_wdata,
    input  logic        m0_cmd_read,
    input  logic [3:0]  m0_cmd_wmask,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_cmd_valid,
    output logic        m1_cmd_ready,
    input  logic [31:0] m1_cmd_addr,
    input  logic [31:0] m1_cmd_wdata,
    input  logic        m1_cmd_read,
    input  logic [3:0]  m1_cmd_wmask,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic        s_cmd_valid,
    input  logic        s_cmd_ready,
    output logic [31:0] s_cmd_addr,
    output logic [31:0] s_cmd_wdata,
    output logic        s_cmd_read,
    output logic [3:0]  s_cmd_wmask,
    input  logic        s_rsp_valid,
    output logic        s_rsp_ready,
    input  logic [31:0] s_rsp_rdata,
    input  logic        s_rsp_err,

    output logic        busy,
    output logic        tmo_pulse
);

    localparam int              CW      = $clog2(TMO_CYC);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TMO_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          gnt_q, gnt_d;      // owner of the transaction: 0 = m0, 1 = m1
    logic          last_q, last_d;    // master granted most recently
    logic          drain_q, drain_d;  // a timed-out response is still owed by the slave
    logic [CW-1:0] cnt_q, cnt_d;      // RSP cycles spent without s_rsp_valid

    logic          g_rsp_ready;
    logic          tmo_hit;

    assign g_rsp_ready = gnt_q ? m1_rsp_ready : m0_rsp_ready;

    // Timeout fires only when no response is present; a response arriving
    // on the last counted cycle is served normally.
    assign tmo_hit = (state_q == ST_RSP) && !s_rsp_valid && (cnt_q == CNT_MAX);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;

        // The first slave response seen while draining is the late one.
        if (drain_q && s_rsp_valid) begin
            drain_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!drain_q && (m0_cmd_valid || m1_cmd_valid)) begin
                    // On conflict the master not granted last wins; with a
                    // single requester, m1_cmd_valid alone selects the owner.
                    if (m0_cmd_valid && m1_cmd_valid) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = m1_cmd_valid;
                    end
                    last_d  = gnt_d;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (s_cmd_ready) begin
                    state_d = ST_RSP;
                    cnt_d   = '0;
                end
            end
            ST_RSP: begin
                if (s_rsp_valid) begin
                    if (g_rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_ERR;
                    drain_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ERR: begin
                if (g_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            drain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic (command fields are muxed, never registered)
    // -----------------------------------------------------------------------
    always_comb begin
        m0_cmd_ready = 1'b0;
        m1_cmd_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m0_rsp_rdata = 32'h0;
        m0_rsp_err   = 1'b0;
        m1_rsp_valid = 1'b0;
        m1_rsp_rdata = 32'h0;
        m1_rsp_err   = 1'b0;
        s_cmd_valid  = 1'b0;
        s_cmd_addr   = 32'h0;
        s_cmd_wdata  = 32'h0;
        s_cmd_read   = 1'b0;
        s_cmd_wmask  = 4'h0;
        s_rsp_ready  = 1'b0;

        case (state_q)
            ST_CMD: begin
                s_cmd_valid = 1'b1;
                if (gnt_q) begin
                    s_cmd_addr   = m1_cmd_addr;
                    s_cmd_wdata  = m1_cmd_wdata;
                    s_cmd_read   = m1_cmd_read;
                    s_cmd_wmask  = m1_cmd_wmask;
                    m1_cmd_ready = s_cmd_ready;
                end else begin
                    s_cmd_addr   = m0_cmd_addr;
                    s_cmd_wdata  = m0_cmd_wdata;
                    s_cmd_read   = m0_cmd_read;
                    s_cmd_wmask  = m0_cmd_wmask;
                    m0_cmd_ready = s_cmd_ready;
                end
            end
            ST_RSP: begin
                s_rsp_ready = g_rsp_ready;
                if (gnt_q) begin
                    m1_rsp_valid = s_rsp_valid;
                    m1_rsp_rdata = s_rsp_rdata;
                    m1_rsp_err   = s_rsp_err;
                end else begin
                    m0_rsp_valid = s_rsp_valid;
                    m0_rsp_rdata = s_rsp_rdata;
                    m0_rsp_err   = s_rsp_err;
                end
            end
            ST_ERR: begin
                // Synthesised error response; rdata stays zero.
                if (gnt_q) begin
                    m1_rsp_valid = 1'b1;
                    m1_rsp_err   = 1'b1;
                end else begin
                    m0_rsp_valid = 1'b1;
                    m0_rsp_err   = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // While draining, the slave side is always accepted and the late
        // response reaches no master.
        if (drain_q) begin
            s_rsp_ready = 1'b1;
        end
    end

    assign busy      = (state_q != ST_IDLE) || drain_q;
    assign tmo_pulse = tmo_hit;

endmodule

// File: tb/tb_dbg_icb_arb.sv
// ---------------------------------------------------------------------------
// tb_dbg_icb_arb
//
// Bench for dbg_icb_arb with a 4-cycle slave timeout. A transaction-level
// model of the arbiter (who owns the bus, what it is waiting for, how long
// the slave has been silent, whether a late response is owed) predicts every
// output each cycle. Directed scenarios pin literal values; a randomized
// phase then exercises arbitration, stalls, timeouts and resets.
// ---------------------------------------------------------------------------
module tb_dbg_icb_arb;

    localparam int TMO = 4;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT signals
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
    logic [3:0]  m0_cmd_wmask;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
    logic [3:0]  m1_cmd_wmask;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
    logic [3:0]  s_cmd_wmask;
    logic        busy, tmo_pulse;

    always #5 clk = ~clk;

    dbg_icb_arb #(.TMO_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_cmd_valid (m0_cmd_valid),
        .m0_cmd_ready (m0_cmd_ready),
        .m0_cmd_addr  (m0_cmd_addr),
        .m0_cmd_wdata (m0_cmd_wdata),
        .m0_cmd_read  (m0_cmd_read),
        .m0_cmd_wmask (m0_cmd_wmask),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_cmd_valid (m1_cmd_valid),
        .m1_cmd_ready (m1_cmd_ready),
        .m1_cmd_addr  (m1_cmd_addr),
        .m1_cmd_wdata (m1_cmd_wdata),
        .m1_cmd_read  (m1_cmd_read),
        .m1_cmd_wmask (m1_cmd_wmask),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .s_cmd_addr   (s_cmd_addr),
        .s_cmd_wdata  (s_cmd_wdata),
        .s_cmd_read   (s_cmd_read),
        .s_cmd_wmask  (s_cmd_wmask),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_ready  (s_rsp_ready),
        .s_rsp_rdata  (s_rsp_rdata),
        .s_rsp_err    (s_rsp_err),
        .busy         (busy),
        .tmo_pulse    (tmo_pulse)
    );

    // -----------------------------------------------------------------------
    // Scoreboard counters and compare helpers
    // -----------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: what the arbiter is doing at transaction level
    // -----------------------------------------------------------------------
    localparam int P_FREE  = 0;  // nobody owns the bus
    localparam int P_ISSUE = 1;  // owner's command is offered to the slave
    localparam int P_WAIT  = 2;  // waiting for the slave's response
    localparam int P_FAULT = 3;  // slave silent too long, error owed to owner

    int md_phase  = P_FREE;
    int md_owner  = 0;
    int md_last   = 1;
    int md_waited = 0;
    bit md_drain  = 1'b0;

    function automatic int md_pick();
        if (m0_cmd_valid && m1_cmd_valid) return 1 - md_last;
        return m1_cmd_valid ? 1 : 0;
    endfunction

    function automatic logic md_owner_rsp_ready();
        return (md_owner == 0) ? m0_rsp_ready : m1_rsp_ready;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_phase  <= P_FREE;
            md_owner  <= 0;
            md_last   <= 1;
            md_waited <= 0;
            md_drain  <= 1'b0;
        end else begin
            if (md_drain && s_rsp_valid) md_drain <= 1'b0;
            case (md_phase)
                P_FREE: begin
                    if (!md_drain && (m0_cmd_valid || m1_cmd_valid)) begin
                        md_owner <= md_pick();
                        md_last  <= md_pick();
                        md_phase <= P_ISSUE;
                    end
                end
                P_ISSUE: begin
                    if (s_cmd_ready) begin
                        md_phase  <= P_WAIT;
                        md_waited <= 0;
                    end
                end
                P_WAIT: begin
                    if (s_rsp_valid) begin
                        if (md_owner_rsp_ready()) md_phase <= P_FREE;
                    end else if (md_waited == TMO - 1) begin
                        md_phase <= P_FAULT;
                        md_drain <= 1'b1;
                    end else begin
                        md_waited <= md_waited + 1;
                    end
                end
                default: begin
                    if (md_owner_rsp_ready()) md_phase <= P_FREE;
                end
            endcase
        end
    end

    task automatic cmp_all();
        logic issue, waitp, fault, o0, o1;
        logic [31:0] f_addr, f_wdata;
        logic [3:0]  f_wmask;
        logic        f_read;
        issue   = (md_phase == P_ISSUE);
        waitp   = (md_phase == P_WAIT);
        fault   = (md_phase == P_FAULT);
        o0      = (md_owner == 0);
        o1      = (md_owner == 1);
        f_addr  = issue ? (o0 ? m0_cmd_addr  : m1_cmd_addr)  : 32'h0;
        f_wdata = issue ? (o0 ? m0_cmd_wdata : m1_cmd_wdata) : 32'h0;
        f_wmask = issue ? (o0 ? m0_cmd_wmask : m1_cmd_wmask) : 4'h0;
        f_read  = issue ? (o0 ? m0_cmd_read  : m1_cmd_read)  : 1'b0;
        chk1 ("mdl_s_cmd_valid",  s_cmd_valid, issue);
        chk32("mdl_s_cmd_addr",   s_cmd_addr,  f_addr);
        chk32("mdl_s_cmd_wdata",  s_cmd_wdata, f_wdata);
        chk32("mdl_s_cmd_wmask",  {28'h0, s_cmd_wmask}, {28'h0, f_wmask});
        chk1 ("mdl_s_cmd_read",   s_cmd_read,  f_read);
        chk1 ("mdl_m0_cmd_ready", m0_cmd_ready, issue && o0 && s_cmd_ready);
        chk1 ("mdl_m1_cmd_ready", m1_cmd_ready, issue && o1 && s_cmd_ready);
        chk1 ("mdl_m0_rsp_valid", m0_rsp_valid, o0 && ((waitp && s_rsp_valid) || fault));
        chk1 ("mdl_m1_rsp_valid", m1_rsp_valid, o1 && ((waitp && s_rsp_valid) || fault));
        chk32("mdl_m0_rsp_rdata", m0_rsp_rdata, (o0 && waitp) ? s_rsp_rdata : 32'h0);
        chk32("mdl_m1_rsp_rdata", m1_rsp_rdata, (o1 && waitp) ? s_rsp_rdata : 32'h0);
        chk1 ("mdl_m0_rsp_err",   m0_rsp_err, o0 && ((waitp && s_rsp_err) || fault));
        chk1 ("mdl_m1_rsp_err",   m1_rsp_err, o1 && ((waitp && s_rsp_err) || fault));
        chk1 ("mdl_s_rsp_ready",  s_rsp_ready,
              md_drain || (waitp && (o0 ? m0_rsp_ready : m1_rsp_ready)));
        chk1 ("mdl_busy",         busy, (md_phase != P_FREE) || md_drain);
        chk1 ("mdl_tmo_pulse",    tmo_pulse, waitp && !s_rsp_valid && (md_waited == TMO - 1));
    endtask

    // One compare process, every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            cmp_all();
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        m0_cmd_valid = 1'b0; m0_cmd_addr = 32'h0; m0_cmd_wdata = 32'h0;
        m0_cmd_read  = 1'b0; m0_cmd_wmask = 4'h0; m0_rsp_ready = 1'b0;
        m1_cmd_valid = 1'b0; m1_cmd_addr = 32'h0; m1_cmd_wdata = 32'h0;
        m1_cmd_read  = 1'b0; m1_cmd_wmask = 4'h0; m1_rsp_ready = 1'b0;
        s_cmd_ready  = 1'b0; s_rsp_valid  = 1'b0; s_rsp_rdata = 32'h0;
        s_rsp_err    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic settle(input int n);
        quiet_inputs();
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Expected grant order for the conflict scenario.
    logic [1:0] exp_q[$];
    logic       hs0, hs1;
    int         grants;
    logic [1:0] got_gnt;

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        quiet_inputs();

        // Reset state
        @(negedge clk);
        chk1 ("rst_busy",         busy, 1'b0);
        chk1 ("rst_s_cmd_valid",  s_cmd_valid, 1'b0);
        chk1 ("rst_s_rsp_ready",  s_rsp_ready, 1'b0);
        chk1 ("rst_m0_rsp_valid", m0_rsp_valid, 1'b0);
        chk1 ("rst_tmo_pulse",    tmo_pulse, 1'b0);
        chk32("rst_s_cmd_addr",   s_cmd_addr, 32'h0);
        cyc();
        rst = 1'b0;

        // Single m0 read, response two cycles after the command is accepted
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h8000_0010; m0_cmd_read = 1'b1;
        s_cmd_ready  = 1'b1; m0_rsp_ready = 1'b1;
        @(negedge clk);
        chk1 ("rd_lat_idle",      s_cmd_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1 ("rd_s_cmd_valid",   s_cmd_valid, 1'b1);
        chk32("rd_s_cmd_addr",    s_cmd_addr, 32'h8000_0010);
        chk1 ("rd_s_cmd_read",    s_cmd_read, 1'b1);
        chk1 ("rd_m0_cmd_ready",  m0_cmd_ready, 1'b1);
        chk1 ("rd_m1_cmd_ready",  m1_cmd_ready, 1'b0);
        cyc();
        m0_cmd_valid = 1'b0;
        cyc();
        cyc();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1234_5678; s_rsp_err = 1'b0;
        @(negedge clk);
        chk1 ("rd_m0_rsp_valid",  m0_rsp_valid, 1'b1);
        chk32("rd_m0_rsp_rdata",  m0_rsp_rdata, 32'h1234_5678);
        chk1 ("rd_m0_rsp_err",    m0_rsp_err, 1'b0);
        chk1 ("rd_m1_rsp_valid",  m1_rsp_valid, 1'b0);
        cyc();
        settle(2);

        // Both masters request continuously from reset: m0, m1, m0, m1,
        // one grant every 3 cycles.
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
        grants = 0;
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h0000_0100; m0_cmd_read = 1'b1;
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h0000_0200; m1_cmd_read = 1'b1;
        s_cmd_ready = 1'b1; s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_00AA;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            hs0 = m0_cmd_valid && m0_cmd_ready;
            hs1 = m1_cmd_valid && m1_cmd_ready;
            if (s_cmd_valid && s_cmd_ready) begin
                got_gnt = m0_cmd_ready ? 2'd0 : (m1_cmd_ready ? 2'd1 : 2'd2);
                grants++;
                if (exp_q.size() > 0) begin
                    chk32("rr_grant_order", {30'h0, got_gnt}, {30'h0, exp_q.pop_front()});
                end else begin
                    chk32("rr_extra_grant", {30'h0, got_gnt}, 32'hFFFF_FFFF);
                end
                if (got_gnt == 2'd0) chk1("rr_m1_ready_low", m1_cmd_ready, 1'b0);
                else                 chk1("rr_m0_ready_low", m0_cmd_ready, 1'b0);
            end
            cyc();
            if (hs0) m0_cmd_addr = m0_cmd_addr + 32'h4;
            if (hs1) m1_cmd_addr = m1_cmd_addr + 32'h4;
        end
        chk32("rr_grant_count", grants, 32'd4);
        settle(3);

        // Timeout: slave never answers
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h8000_0100; m0_cmd_read = 1'b1;
        s_cmd_ready = 1'b1;
        cyc();
        cyc();
        m0_cmd_valid = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk1 ("tmo_early_pulse",  tmo_pulse, 1'b0);
        cyc();
        @(negedge clk);
        chk1 ("tmo_pulse_hi",     tmo_pulse, 1'b1);
        chk1 ("tmo_busy",         busy, 1'b1);
        chk1 ("tmo_no_rsp_yet",   m0_rsp_valid, 1'b0);
        cyc();
        m0_rsp_ready = 1'b1;
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h4000_0020; m1_cmd_wdata = 32'hA5A5_5A5A;
        m1_cmd_read  = 1'b0; m1_cmd_wmask = 4'hF;
        @(negedge clk);
        chk1 ("err_pulse_low",    tmo_pulse, 1'b0);
        chk1 ("err_m0_rsp_valid", m0_rsp_valid, 1'b1);
        chk1 ("err_m0_rsp_err",   m0_rsp_err, 1'b1);
        chk32("err_m0_rsp_rdata", m0_rsp_rdata, 32'h0);
        chk1 ("err_s_rsp_ready",  s_rsp_ready, 1'b1);
        chk1 ("err_m1_cmd_ready", m1_cmd_ready, 1'b0);
        cyc();
        m0_rsp_ready = 1'b0;

        // Late response while m1 is pending: no grant until it is drained
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk1("drain_no_grant", s_cmd_valid, 1'b0);
            chk1("drain_busy",     busy, 1'b1);
            cyc();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1 ("late_s_rsp_ready", s_rsp_ready, 1'b1);
        chk1 ("late_m0_dropped",  m0_rsp_valid, 1'b0);
        chk1 ("late_m1_dropped",  m1_rsp_valid, 1'b0);
        cyc();
        s_rsp_valid = 1'b0;
        @(negedge clk);
        chk1 ("late_busy_clear",  busy, 1'b0);
        chk1 ("late_no_cmd_yet",  s_cmd_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1 ("late_m1_granted",  m1_cmd_ready, 1'b1);
        chk32("late_m1_addr",     s_cmd_addr, 32'h4000_0020);
        chk32("late_m1_wmask",    {28'h0, s_cmd_wmask}, 32'hF);
        chk1 ("late_m1_write",    s_cmd_read, 1'b0);
        cyc();
        m1_cmd_valid = 1'b0; m1_rsp_ready = 1'b1;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0000_0001;
        @(negedge clk);
        chk1 ("late_m1_rsp",      m1_rsp_valid, 1'b1);
        chk32("late_m1_rdata",    m1_rsp_rdata, 32'h0000_0001);
        cyc();
        settle(3);

        // Response on the last counted cycle wins over the timeout
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h8000_0200; m0_cmd_read = 1'b1;
        s_cmd_ready = 1'b1; m0_rsp_ready = 1'b1;
        cyc();
        cyc();
        m0_cmd_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        chk1 ("edge_rsp_valid",   m0_rsp_valid, 1'b1);
        chk32("edge_rsp_rdata",   m0_rsp_rdata, 32'h0BAD_CAFE);
        chk1 ("edge_rsp_err",     m0_rsp_err, 1'b0);
        chk1 ("edge_no_tmo",      tmo_pulse, 1'b0);
        cyc();
        s_rsp_valid = 1'b0;
        @(negedge clk);
        chk1 ("edge_idle",        busy, 1'b0);
        settle(2);

        // Reset while waiting for a response
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h8000_0300; m0_cmd_read = 1'b1;
        s_cmd_ready = 1'b1;
        cyc();
        cyc();
        m0_cmd_valid = 1'b0; m0_rsp_ready = 1'b1;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h5555_AAAA;
        #1;
        chk1 ("rsprst_pre_valid", m0_rsp_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1 ("rsprst_m0_rsp",    m0_rsp_valid, 1'b0);
        chk32("rsprst_m0_rdata",  m0_rsp_rdata, 32'h0);
        chk1 ("rsprst_s_rdy",     s_rsp_ready, 1'b0);
        chk1 ("rsprst_busy",      busy, 1'b0);
        cyc();
        rst = 1'b0;
        quiet_inputs();
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h1000_0040; m1_cmd_wdata = 32'hCAFE_F00D;
        m1_cmd_read  = 1'b0; m1_cmd_wmask = 4'hF; m1_rsp_ready = 1'b1; s_cmd_ready = 1'b1;
        @(negedge clk);
        chk1 ("post_idle",        s_cmd_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk1 ("post_m1_ready",    m1_cmd_ready, 1'b1);
        chk32("post_wdata",       s_cmd_wdata, 32'hCAFE_F00D);
        chk32("post_wmask",       {28'h0, s_cmd_wmask}, 32'hF);
        cyc();
        m1_cmd_valid = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h0;
        @(negedge clk);
        chk1 ("post_m1_rsp",      m1_rsp_valid, 1'b1);
        chk1 ("post_m1_err",      m1_rsp_err, 1'b0);
        cyc();
        settle(2);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            hs0 = m0_cmd_valid && m0_cmd_ready;
            hs1 = m1_cmd_valid && m1_cmd_ready;
            cyc();
            if (rst) rst = 1'b0;
            if (!m0_cmd_valid || hs0) begin
                m0_cmd_valid = ($urandom_range(0, 2) == 0);
                m0_cmd_addr  = $urandom;
                m0_cmd_wdata = $urandom;
                m0_cmd_read  = 1'($urandom_range(0, 1));
                m0_cmd_wmask = 4'($urandom_range(0, 15));
            end
            if (!m1_cmd_valid || hs1) begin
                m1_cmd_valid = ($urandom_range(0, 1) == 0);
                m1_cmd_addr  = $urandom;
                m1_cmd_wdata = $urandom;
                m1_cmd_read  = 1'($urandom_range(0, 1));
                m1_cmd_wmask = 4'($urandom_range(0, 15));
            end
            s_cmd_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_valid  = ($urandom_range(0, 3) == 0);
            s_rsp_rdata  = $urandom;
            s_rsp_err    = ($urandom_range(0, 7) == 0);
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        settle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
